// File: rtl/twofish_mds_mul_if.sv
// Operand/result handshake bundle for the Twofish MDS multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface twofish_mds_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;

  modport master (output in_valid, in_y, out_ready,
                  input  in_ready, out_valid, out_z);
  modport slave  (input  in_valid, in_y, out_ready,
                  output in_ready, out_valid, out_z);
endinterface

// File: rtl/twofish_mds_mul.sv
// Twofish MDS multiply over GF(2^8)/0x169. By default it evaluates one matrix row per cycle.
// With MDS_PARALLEL_EN defined, all four rows are evaluated in a single compute cycle.
module twofish_mds_mul #(
  parameter logic [7:0] POLY_LO = 8'h69
) (
  input  logic             clk,
  input  logic             rst,
  twofish_mds_mul_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [3:0][7:0]  r_opnd;
  logic             r_out_valid;
  logic [31:0]      r_out_z;
  logic [3:0][7:0]  w_p5b, w_pef;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY_LO : 8'h00);
  endfunction

  // Both constants are built from one doubling chain of the operand byte.
  function automatic logic [1:0][7:0] mul_5b_ef(input logic [7:0] a);
    logic [7:0] a2, a4, a8, a16, a32, a64, a128;
    a2   = xt(a);
    a4   = xt(a2);
    a8   = xt(a4);
    a16  = xt(a8);
    a32  = xt(a16);
    a64  = xt(a32);
    a128 = xt(a64);
    return {a ^ a2 ^ a4 ^ a8 ^ a32 ^ a64 ^ a128,
            a ^ a2 ^ a8 ^ a16 ^ a64};
  endfunction

  // Coefficient code per column: 0 -> 01, 1 -> 5B, 2 -> EF.
  function automatic logic [3:0][1:0] row_codes(input logic [1:0] r);
    case (r)
      2'd0:    return 8'b01_01_10_00;
      2'd1:    return 8'b00_10_10_01;
      2'd2:    return 8'b10_00_01_10;
      default: return 8'b01_10_00_10;
    endcase
  endfunction

  function automatic logic [7:0] row_z(input logic [1:0] r, input logic [3:0][7:0] y,
                                      input logic [3:0][7:0] p5, input logic [3:0][7:0] pe);
    logic [3:0][1:0] c;
    logic [7:0]      acc;
    c   = row_codes(r);
    acc = 8'h00;
    for (int j = 0; j < 4; j++) begin
      case (c[j])
        2'd0:    acc = acc ^ y[j];
        2'd1:    acc = acc ^ p5[j];
        default: acc = acc ^ pe[j];
      endcase
    end
    return acc;
  endfunction

  for (genvar j = 0; j < 4; j++) begin : g_col
    assign {w_pef[j], w_p5b[j]} = mul_5b_ef(r_opnd[j]);
  end

`ifdef MDS_PARALLEL_EN
  logic [3:0][7:0] w_zall;

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign w_zall[i] = row_z(2'(i), r_opnd, w_p5b, w_pef);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opnd      <= '0;
      r_out_valid <= 1'b0;
      r_out_z     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_opnd  <= bus.in_y;
          r_state <= S_BUSY;
        end
        // Single compute cycle: all rows land in the output register at once.
        S_BUSY: begin
          r_out_z     <= w_zall;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  logic [1:0]      r_row;
  logic [3:0][7:0] r_res;
  logic [7:0]      w_zr;

  assign w_zr = row_z(r_row, r_opnd, w_p5b, w_pef);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= 2'd0;
      r_opnd      <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_z     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_opnd  <= bus.in_y;
          r_row   <= 2'd0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_res[r_row] <= w_zr;
          r_row        <= r_row + 2'd1;
          // Last row bypasses r_res so the full word reaches out_z on DONE entry.
          if (r_row == 2'd3) begin
            r_out_z     <= {w_zr, r_res[2], r_res[1], r_res[0]};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;

endmodule

// File: tb/tb_twofish_mds_mul.sv
// Directed and random stream bench for twofish_mds_mul.
module tb_twofish_mds_mul;

`ifdef MDS_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam int TMO = 60;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] mtx [4][4];

  always #5 clk = ~clk;

  twofish_mds_mul_if bus ();

  twofish_mds_mul #(.POLY_LO(8'h69)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h69) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] mds(input logic [31:0] y);
    logic [31:0] z;
    z = 32'h0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        z[8*i +: 8] = z[8*i +: 8] ^ gmul(mtx[i][j], y[8*j +: 8]);
    return z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one operand, wait for the result, then complete the output handshake.
  task automatic do_op(input logic [31:0] y, output logic [31:0] z, output int lat);
    int k;
    bus.in_valid = 1'b1;
    bus.in_y     = y;
    k = 0;
    while (!bus.in_ready && k < TMO) begin tick(); k++; end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < TMO) begin tick(); lat++; end
    z = bus.out_z;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_y = 32'h12345678;
    bus.out_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_z !== 32'h0) begin
      n_bad++; $display("FAIL rst_out: got v=%b z=%h want v=0 z=00000000", bus.out_valid, bus.out_z);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vin [7];
    logic [31:0] vexp [7];
    logic [31:0] z;
    int lat;
    vin  = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000,
             32'h01010101, 32'h00000002, 32'h00000000};
    vexp = '{32'hEFEF5B01, 32'h015BEFEF, 32'hEF01EF5B, 32'h5BEF015B,
             32'h5A5A5AEE, 32'hB7B7B602, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      do_op(vin[i], z, lat);
      n_cmp++;
      if (z !== vexp[i]) begin
        n_bad++; $display("FAIL vec%0d_z: in=%h got %h want %h", i, vin[i], z, vexp[i]);
      end
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_z !== vexp[i]) begin
        n_bad++; $display("FAIL vec%0d_after_hs: got v=%b z=%h want v=0 z=%h",
                          i, bus.out_valid, bus.out_z, vexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k, lat;
    bus.in_valid = 1'b1;
    bus.in_y = 32'h00000001;
    k = 0;
    while (!bus.in_ready && k < TMO) begin tick(); k++; end
    tick();
    bus.in_y = 32'h00000002;
    k = 0;
    while (!bus.out_valid && k < TMO) begin tick(); k++; end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_z !== 32'hEFEF5B01 || bus.in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b z=%h rdy=%b want v=1 z=efef5b01 rdy=0",
                          c, bus.out_valid, bus.out_z, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_accept: got rdy=%b want 0", bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < TMO) begin tick(); lat++; end
    n_cmp++;
    if (bus.out_z !== 32'hB7B7B602 || lat !== LAT) begin
      n_bad++; $display("FAIL bp_second: got z=%h lat=%0d want z=b7b7b602 lat=%0d", bus.out_z, lat, LAT);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int k, lat;
    bus.in_valid = 1'b1;
    bus.in_y = 32'h00000001;
    k = 0;
    while (!bus.in_ready && k < TMO) begin tick(); k++; end
    tick();
    bus.in_valid = 1'b0;
`ifndef MDS_PARALLEL_EN
    tick(); tick();
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_z !== 32'h0) begin
        n_bad++; $display("FAIL midrst_quiet%0d: got v=%b z=%h want v=0 z=00000000",
                          c, bus.out_valid, bus.out_z);
      end
      tick();
    end
    do_op(32'h00000001, z, lat);
    n_cmp++;
    if (z !== 32'hEFEF5B01 || lat !== LAT) begin
      n_bad++; $display("FAIL midrst_next: got z=%h lat=%0d want z=efef5b01 lat=%0d", z, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq [$];
    logic [31:0] yi, zo, want;
    logic fire_in, fire_out;
    int sent, got, cyc, nbad0;
    sent = 0; got = 0; cyc = 0;
    nbad0 = n_bad;
    bus.in_valid = 1'b0;
    while (got < 1000 && cyc < 40000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_y = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 1) == 1);
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      yi = bus.in_y;
      zo = bus.out_z;
      tick();
      cyc++;
      if (fire_in) begin
        expq.push_back(mds(yi));
        sent++;
        bus.in_valid = 1'b0;
      end
      if (fire_out) begin
        want = (expq.size() > 0) ? expq[0] : ~zo;
        n_cmp++;
        if (zo !== want) begin
          n_bad++;
          if (n_bad - nbad0 < 10) $display("FAIL stream%0d: got %h want %h", got, zo, want);
        end
        if (expq.size() > 0) void'(expq.pop_front());
        got++;
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got !== 1000 || expq.size() !== 0) begin
      n_bad++; $display("FAIL stream_count: got %0d results, %0d pending, want 1000 and 0", got, expq.size());
    end
  endtask

  initial begin
    mtx[0] = '{8'h01, 8'hEF, 8'h5B, 8'h5B};
    mtx[1] = '{8'h5B, 8'hEF, 8'hEF, 8'h01};
    mtx[2] = '{8'hEF, 8'h5B, 8'h01, 8'hEF};
    mtx[3] = '{8'hEF, 8'h01, 8'hEF, 8'h5B};
    bus.in_valid = 1'b0;
    bus.in_y = 32'h0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
